// File: rtl/ca_reg_digit_reader.sv
// ca_reg_digit_reader: read side of the CA register path. Fetches 16-bit RAM
// words holding four {x+, x-, y+, y-} digit nibbles and streams them out one
// digit pair per valid/ready handshake, digit 0 (bits [3:0]) first. A one-word
// prefetch buffer keeps the stream contiguous across word boundaries.
module ca_reg_digit_reader #(
    parameter int ADDR_W = 7,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_rd_data,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic              x_plus,
    output logic              x_minus,
    output logic              y_plus,
    output logic              y_minus,
    output logic [1:0]        digit_idx,
    output logic              busy,
    output logic              done,
    output logic              digit_err
);

    // One extra bit so a full 2^ADDR_W word count can never overflow.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   loaded_q;
    logic               in_flight_q;
    logic [WORD_W-1:0]  pf_buf_q;
    logic               pf_valid_q;
    logic [WORD_W-1:0]  cur_word_q;
    logic               cur_valid_q;
    logic [1:0]         idx_q;
    logic               err_q;

    logic start_acc;
    logic accept;
    logic word_end;
    logic cur_free;
    logic load_pf;
    logic load_ram;
    logic last_acc;
    logic issue;

    // Handshake, load/prefetch decisions and FSM next state.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
        state_d   = state_q;
        start_acc = (state_q == S_IDLE) && start;
        accept    = cur_valid_q && digit_ready;
        word_end  = accept && (idx_q == 2'd3);
        cur_free  = !cur_valid_q || word_end;
        load_pf   = cur_free && pf_valid_q;
        // First word of a stream (or a starved shift register) takes RAM data
        // directly, which is what gives the two-cycle first-digit latency.
        load_ram  = cur_free && !pf_valid_q && in_flight_q;
        last_acc  = word_end && (loaded_q == num_q);
        issue     = ((state_q == S_FETCH) || (state_q == S_STREAM)) &&
                    (issued_q < num_q) && !in_flight_q &&
                    (!pf_valid_q || load_pf);

        case (state_q)
            S_IDLE: begin
                if (start) state_d = (num_words == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (load_ram) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (last_acc) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: read tracking, prefetch buffer, digit shift register, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data words are reset as well, so outputs and buffers never expose pre-reset contents.
            base_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            loaded_q    <= '0;
            in_flight_q <= 1'b0;
            pf_buf_q    <= '0;
            pf_valid_q  <= 1'b0;
            cur_word_q  <= '0;
            cur_valid_q <= 1'b0;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
        end else if (start_acc) begin
            base_q      <= base_addr;
            num_q       <= {1'b0, num_words};
            issued_q    <= '0;
            loaded_q    <= '0;
            in_flight_q <= 1'b0;
            pf_valid_q  <= 1'b0;
            cur_valid_q <= 1'b0;
            idx_q       <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            // Synchronous RAM: anything issued this cycle returns next cycle.
            in_flight_q <= issue;
            if (issue) issued_q <= issued_q + CNT_W'(1);

            if (load_pf || load_ram) begin
                cur_word_q  <= load_pf ? pf_buf_q : ram_rd_data;
                cur_valid_q <= 1'b1;
                idx_q       <= 2'd0;
                loaded_q    <= loaded_q + CNT_W'(1);
            end else if (accept) begin
                cur_word_q <= cur_word_q >> 4;
                idx_q      <= idx_q + 2'd1;
                if (word_end) cur_valid_q <= 1'b0;
            end

            // A returning word not taken straight into the shift register parks here.
            if (in_flight_q && !load_ram) begin
                pf_buf_q   <= ram_rd_data;
                pf_valid_q <= 1'b1;
            end else if (load_pf) begin
                pf_valid_q <= 1'b0;
            end

            if (cur_valid_q && ((cur_word_q[3] & cur_word_q[2]) |
                                (cur_word_q[1] & cur_word_q[0]))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ram_rd_en   = issue;
    assign ram_addr    = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
    assign digit_valid = cur_valid_q;
    assign x_plus      = cur_word_q[3];
    assign x_minus     = cur_word_q[2];
    assign y_plus      = cur_word_q[1];
    assign y_minus     = cur_word_q[0];
    assign digit_idx   = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign digit_err   = err_q;

endmodule
